// File: rtl/adder_pkg.sv
// adder_pkg: definitions shared by parallel_adder, adder_result_accumulator
// and their benches.
//   DEF_DATA_W : default adder operand width
//   DEF_ACC_W  : default accumulator width
//   acc_state_t: accumulator block state (IDLE / ACCUM / DONE)
package adder_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_ACC_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/acc_add_unit.sv
// acc_add_unit: W-bit unsigned combinational adder.
//   a, b : operands
//   sum  : (a + b) mod 2**W
//   cout : carry out of bit W-1
module acc_add_unit #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator: sums BLOCK_LEN {carry, sum} results from the
// parallel adder into an ACC_W-bit total, presented on a valid/ready output.
//   clk, rst             : clock (rising edge), async active-high reset
//   clear                : synchronous abort of the current block
//   in_valid / in_ready  : input handshake for sum_in / carry_in
//   sum_in, carry_in     : adder result, carry_in is the operand MSB
//   out_valid / out_ready: output handshake for the completed total
//   acc_out              : running / final total
//   count_out            : results accepted in the current block
//   overflow             : sticky wrap indicator for the current block
module adder_result_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned BLOCK_LEN = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sum_in,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              overflow
);

  acc_state_t       state, state_next;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic [ACC_W-1:0] op;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic             take_in;
  logic             take_out;

  assign in_ready  = (state != ST_DONE);
  assign out_valid = (state == ST_DONE);
  assign take_in   = in_valid & in_ready;
  assign take_out  = out_valid & out_ready;

  always_comb begin
    op             = '0;
    op[DATA_W:0]   = {carry_in, sum_in};
  end

  // In IDLE the register already reads 0, but forcing the addend to 0 keeps
  // the first result independent of any stale accumulator content.
  assign add_a = (state == ST_IDLE) ? '0 : acc_out;

  acc_add_unit #(
    .W (ACC_W)
  ) u_add (
    .a    (add_a),
    .b    (op),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_next = state;
    acc_next   = acc_out;
    cnt_next   = count_out;
    ovf_next   = overflow;
    unique case (state)
      ST_IDLE: begin
        if (take_in) begin
          acc_next   = add_sum;
          cnt_next   = CNT_W'(1);
          ovf_next   = add_cout;
          state_next = (BLOCK_LEN == 1) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (take_in) begin
          acc_next = add_sum;
          cnt_next = count_out + CNT_W'(1);
          ovf_next = overflow | add_cout;
          if (count_out == CNT_W'(BLOCK_LEN - 1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (take_out) begin
          state_next = ST_IDLE;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        acc_next   = '0;
        cnt_next   = '0;
        ovf_next   = 1'b0;
      end
    endcase
    // Abort overrides any coincident input transfer.
    if (clear) begin
      state_next = ST_IDLE;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc_out   <= '0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      acc_out   <= acc_next;
      count_out <= cnt_next;
      overflow  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
module tb_adder_result_accumulator;

  typedef struct {
    int unsigned acc;
    int unsigned ovf;
    int unsigned cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // DUT a: defaults (ACC_W=8, BLOCK_LEN=8)
  logic       a_clear = 0, a_in_valid = 0, a_carry = 0, a_out_ready = 0;
  logic [3:0] a_sum = '0;
  logic       a_in_ready, a_out_valid, a_ovf;
  logic [7:0] a_acc;
  logic [3:0] a_cnt;

  // DUT b: ACC_W=6, BLOCK_LEN=3
  logic       b_in_valid = 0, b_carry = 0, b_out_ready = 0;
  logic [3:0] b_sum = '0;
  logic       b_in_ready, b_out_valid, b_ovf;
  logic [5:0] b_acc;
  logic [3:0] b_cnt;

  // DUT c: BLOCK_LEN=1
  logic       c_in_valid = 0, c_carry = 0, c_out_ready = 0;
  logic [3:0] c_sum = '0;
  logic       c_in_ready, c_out_valid, c_ovf;
  logic [7:0] c_acc;
  logic [3:0] c_cnt;

  adder_result_accumulator #(.DATA_W(4), .ACC_W(8), .BLOCK_LEN(8), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sum_in(a_sum), .carry_in(a_carry), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .acc_out(a_acc), .count_out(a_cnt), .overflow(a_ovf));

  adder_result_accumulator #(.DATA_W(4), .ACC_W(6), .BLOCK_LEN(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sum_in(b_sum), .carry_in(b_carry), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .acc_out(b_acc), .count_out(b_cnt), .overflow(b_ovf));

  adder_result_accumulator #(.DATA_W(4), .ACC_W(8), .BLOCK_LEN(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sum_in(c_sum), .carry_in(c_carry), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .acc_out(c_acc), .count_out(c_cnt), .overflow(c_ovf));

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input string tag, inout exp_t q[$], input int unsigned acc,
                         input int unsigned ovf, input int unsigned cnt);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_unexpected_output"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, "_acc"}, acc, e.acc);
      chk({tag, "_ovf"}, ovf, e.ovf);
      chk({tag, "_cnt"}, cnt, e.cnt);
    end
  endtask

  // Monitors: compare on every output transfer, just before the accepting edge.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) pop_chk("a", q_a, a_acc, a_ovf, a_cnt);
    if (!rst && b_out_valid && b_out_ready) pop_chk("b", q_b, b_acc, b_ovf, b_cnt);
    if (!rst && c_out_valid && c_out_ready) pop_chk("c", q_c, c_acc, c_ovf, c_cnt);
  end

  task automatic send_a(input logic [3:0] s, input logic c);
    a_sum = s; a_carry = c; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] s, input logic c);
    b_sum = s; b_carry = c; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset values before any clock edge
    #1;
    chk("rst_acc", a_acc, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_ovf", a_ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", a_in_ready, 1);

    // 1: async reset mid-block, no clock edge
    repeat (3) send_a(4'hF, 1'b1);
    chk("mid_acc", a_acc, 93);
    chk("mid_cnt", a_cnt, 3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_acc", a_acc, 0);
    chk("async_rst_cnt", a_cnt, 0);
    chk("async_rst_out_valid", a_out_valid, 0);
    chk("async_rst_ovf", a_ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", a_in_ready, 1);

    // 2: eight back-to-back op=31
    q_a.push_back('{acc: 248, ovf: 0, cnt: 8});
    repeat (7) send_a(4'hF, 1'b1);
    chk("blk7_out_valid", a_out_valid, 0);
    chk("blk7_acc", a_acc, 217);
    send_a(4'hF, 1'b1);
    chk("blk8_out_valid", a_out_valid, 1);
    chk("blk8_in_ready", a_in_ready, 0);
    chk("blk8_acc", a_acc, 248);
    chk("blk8_ovf", a_ovf, 0);
    chk("blk8_cnt", a_cnt, 8);

    // 3: backpressure, input ignored while DONE
    for (int i = 0; i < 5; i++) begin
      a_sum = 4'hF; a_carry = 1'b1; a_in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_acc", a_acc, 248);
      chk("bp_cnt", a_cnt, 8);
      chk("bp_out_valid", a_out_valid, 1);
    end
    a_in_valid = 1'b0;
    release_a();
    chk("rel_out_valid", a_out_valid, 0);
    chk("rel_acc", a_acc, 0);
    chk("rel_cnt", a_cnt, 0);
    chk("rel_in_ready", a_in_ready, 1);

    // 4: overflow with ACC_W=6
    q_b.push_back('{acc: 29, ovf: 1, cnt: 3});
    send_b(4'hF, 1'b1);
    send_b(4'hF, 1'b1);
    chk("ovf2_ovf", b_ovf, 0);
    chk("ovf2_acc", b_acc, 62);
    send_b(4'hF, 1'b1);
    chk("ovf3_ovf", b_ovf, 1);
    chk("ovf3_acc", b_acc, 29);
    chk("ovf3_out_valid", b_out_valid, 1);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("ovf_clr_ovf", b_ovf, 0);
    chk("ovf_clr_acc", b_acc, 0);

    // 5: clear with coincident input
    repeat (3) send_a(4'h5, 1'b0);
    chk("pre_clear_acc", a_acc, 15);
    a_clear = 1'b1; a_sum = 4'h5; a_carry = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0; a_in_valid = 1'b0;
    chk("clear_acc", a_acc, 0);
    chk("clear_cnt", a_cnt, 0);
    chk("clear_out_valid", a_out_valid, 0);

    // 6: 1..8 back-to-back, then with random gaps
    q_a.push_back('{acc: 36, ovf: 0, cnt: 8});
    for (int i = 1; i <= 8; i++) send_a(4'(i), 1'b0);
    chk("b2b_acc", a_acc, 36);
    release_a();
    q_a.push_back('{acc: 36, ovf: 0, cnt: 8});
    for (int i = 1; i <= 8; i++) begin
      send_a(4'(i), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    chk("gap_acc", a_acc, 36);
    chk("gap_out_valid", a_out_valid, 1);
    release_a();

    // 6: BLOCK_LEN=1
    q_c.push_back('{acc: 9, ovf: 0, cnt: 1});
    c_sum = 4'h9; c_carry = 1'b0; c_in_valid = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    chk("len1_out_valid", c_out_valid, 1);
    chk("len1_acc", c_acc, 9);
    chk("len1_in_ready", c_in_ready, 0);
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    chk("len1_rel_out_valid", c_out_valid, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    chk("q_c_drained", q_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
